// File: rtl/wiener_pkg.sv
// Shared widths, defaults and helpers for the streaming 3x3 Wiener filter.
// Widths are derived from the pixel width so a whole 3x3 window never overflows.
package wiener_pkg;

    localparam int DW_DEFAULT   = 32'sd8;
    localparam int FRAC_DEFAULT = 32'sd16;

    typedef logic [DW_DEFAULT-1:0] pix_t;
    typedef pix_t [8:0]            window_t;

    function automatic int sum_w(input int dw);
        return dw + 32'sd4;
    endfunction

    function automatic int sumsq_w(input int dw);
        return (32'sd2 * dw) + 32'sd4;
    endfunction

    function automatic int var_w(input int dw);
        return (32'sd2 * dw) + 32'sd2;
    endfunction

    // Saturate a signed result into the unsigned pixel range [0, 2^dw-1].
    function automatic logic [31:0] clamp_pix(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< dw) - 64'sd1;
        if (v < 64'sd0) begin
            return 32'd0;
        end else if (v > hi) begin
            return hi[31:0];
        end else begin
            return v[31:0];
        end
    endfunction

endpackage

// File: rtl/wiener_linebuf.sv
// Two-line buffer, 3x3 window column shifter and raster counters.
// The window handed out is the one completed by the pixel currently being accepted.
module wiener_linebuf
    import wiener_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  xfer,
    input  logic [DW-1:0]         pix,
    output logic [8:0][DW-1:0]    win,
    output logic                  fire,
    output logic                  first,
    output logic                  last
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0]        x_r;
    logic [YW-1:0]        y_r;
    logic [DW-1:0]        line0_r [IMG_W];
    logic [DW-1:0]        line1_r [IMG_W];
    logic [2:0][DW-1:0]   col_new_s;
    logic [2:0][DW-1:0]   col1_r;
    logic [2:0][DW-1:0]   col2_r;

    // Column at x: row y-2 from the older line, row y-1, then the incoming pixel.
    always_comb begin
        col_new_s[0] = line1_r[x_r];
        col_new_s[1] = line0_r[x_r];
        col_new_s[2] = pix;
    end

    // Raster-ordered window: columns x-2, x-1, x for each of the three rows.
    always_comb begin
        win = '0;
        for (int r = 0; r < 3; r++) begin
            win[3*r]     = col2_r[r];
            win[3*r + 1] = col1_r[r];
            win[3*r + 2] = col_new_s[r];
        end
    end

    assign fire  = xfer && (x_r >= XW'(32'd2)) && (y_r >= YW'(32'd2));
    assign first = xfer && (x_r == '0) && (y_r == '0);
    assign last  = (x_r == X_LAST) && (y_r == Y_LAST);

    // Line storage is left unreset; rows 0 and 1 of each frame refill it before use.
    always_ff @(posedge clk) begin
        if (xfer) begin
            line1_r[x_r] <= line0_r[x_r];
            line0_r[x_r] <= pix;
        end
    end

    // Raster counters and the two retained window columns.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r    <= '0;
            y_r    <= '0;
            col1_r <= '0;
            col2_r <= '0;
        end else if (xfer) begin
            col2_r <= col1_r;
            col1_r <= col_new_s;
            if (x_r == X_LAST) begin
                x_r <= '0;
                y_r <= (y_r == Y_LAST) ? '0 : y_r + YW'(32'd1);
            end else begin
                x_r <= x_r + XW'(32'd1);
            end
        end
    end

endmodule

// File: rtl/wiener_stream3x3.sv
// Streaming 3x3 Wiener filter: line-buffered windows feed a four-stage stalling
// pipeline (sums, variance, gain, filter/clamp) with a single global stall.
module wiener_stream3x3
    import wiener_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int FRAC  = FRAC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*DW+1:0]       sigma_n2,
    input  logic                  bypass,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DW-1:0]         s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DW-1:0]         m_data,
    output logic                  frame_done
);

    localparam int SW = sum_w(DW);
    localparam int QW = sumsq_w(DW);
    localparam int VW = var_w(DW);
    localparam int MW = 2 * DW;
    localparam int GW = FRAC + 1;
    localparam int NW = VW + FRAC;
    localparam int PW = GW + 1 + DW + 2;

    logic                stall_s, xfer_s, fire_s, first_s, last_s;
    logic [8:0][DW-1:0]  win_s;
    logic [VW-1:0]       sig_r;
    logic                byp_r;

    assign stall_s = m_valid && !m_ready;
    assign s_ready = !rst && !stall_s;
    assign xfer_s  = s_valid && s_ready;

    wiener_linebuf #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) u_linebuf (
        .clk   (clk),
        .rst   (rst),
        .xfer  (xfer_s),
        .pix   (s_data),
        .win   (win_s),
        .fire  (fire_s),
        .first (first_s),
        .last  (last_s)
    );

    // Frame-wide controls are captured with pixel (0,0) only.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_r <= '0;
            byp_r <= 1'b0;
        end else if (first_s) begin
            sig_r <= sigma_n2;
            byp_r <= bypass;
        end
    end

    logic [SW-1:0] sum_s;
    logic [QW-1:0] sumsq_s;

    // Window sum and sum of squares.
    always_comb begin
        sum_s   = '0;
        sumsq_s = '0;
        for (int i = 0; i < 9; i++) begin
            sum_s   = sum_s + SW'(win_s[i]);
            sumsq_s = sumsq_s + (QW'(win_s[i]) * QW'(win_s[i]));
        end
    end

    logic          s1_valid, s1_byp, s1_last;
    logic [SW-1:0] s1_sum;
    logic [QW-1:0] s1_sumsq;
    logic [DW-1:0] s1_p4;
    logic [VW-1:0] s1_sigma;

    // S1: register the sums of the window completed by this transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_byp   <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
            s1_sumsq <= '0;
            s1_p4    <= '0;
            s1_sigma <= '0;
        end else if (!stall_s) begin
            s1_valid <= fire_s;
            if (fire_s) begin
                s1_byp   <= byp_r;
                s1_last  <= last_s;
                s1_sum   <= sum_s;
                s1_sumsq <= sumsq_s;
                s1_p4    <= win_s[4];
                s1_sigma <= sig_r;
            end
        end
    end

    logic [DW-1:0] mean_s;
    logic [MW-1:0] ex2_s, msq_s;
    logic [VW-1:0] var_s;

    assign mean_s = DW'(s1_sum / SW'(32'd9));
    assign ex2_s  = MW'(s1_sumsq / QW'(32'd9));
    assign msq_s  = MW'(mean_s) * MW'(mean_s);
    assign var_s  = (ex2_s > msq_s) ? VW'(ex2_s - msq_s) : '0;

    logic          s2_valid, s2_byp, s2_last;
    logic [DW-1:0] s2_mean, s2_p4;
    logic [VW-1:0] s2_var, s2_sigma;

    // S2: mean and variance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_byp   <= 1'b0;
            s2_last  <= 1'b0;
            s2_mean  <= '0;
            s2_p4    <= '0;
            s2_var   <= '0;
            s2_sigma <= '0;
        end else if (!stall_s) begin
            s2_valid <= s1_valid;
            s2_byp   <= s1_byp;
            s2_last  <= s1_last;
            s2_mean  <= mean_s;
            s2_p4    <= s1_p4;
            s2_var   <= var_s;
            s2_sigma <= s1_sigma;
        end
    end

    logic [VW-1:0] diff_s;
    logic [NW-1:0] num_s, den_s, quo_s;
    logic [GW-1:0] gain_s;

    // The divisor is forced non-zero; the zero-variance case is masked by the select.
    assign diff_s = s2_var - s2_sigma;
    assign num_s  = NW'(diff_s) << FRAC;
    assign den_s  = (s2_var == '0) ? NW'(32'd1) : NW'(s2_var);
    assign quo_s  = num_s / den_s;
    assign gain_s = ((s2_var > s2_sigma) && (s2_var != '0)) ? GW'(quo_s) : '0;

    logic          s3_valid, s3_byp, s3_last;
    logic [DW-1:0] s3_mean, s3_p4;
    logic [GW-1:0] s3_gain;

    // S3: Wiener gain in Q.FRAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_byp   <= 1'b0;
            s3_last  <= 1'b0;
            s3_mean  <= '0;
            s3_p4    <= '0;
            s3_gain  <= '0;
        end else if (!stall_s) begin
            s3_valid <= s2_valid;
            s3_byp   <= s2_byp;
            s3_last  <= s2_last;
            s3_mean  <= s2_mean;
            s3_p4    <= s2_p4;
            s3_gain  <= gain_s;
        end
    end

    logic signed [DW+1:0] delta_s;
    logic signed [PW-1:0] prod_s, shr_s;
    logic signed [PW:0]   filt_s;
    logic [31:0]          clamp_s;
    logic [DW-1:0]        out_s;

    assign delta_s = $signed({2'b00, s3_p4}) - $signed({2'b00, s3_mean});
    assign prod_s  = PW'($signed({1'b0, s3_gain})) * PW'(delta_s);
    assign shr_s   = prod_s >>> FRAC;
    assign filt_s  = $signed({{(PW + 1 - DW){1'b0}}, s3_mean}) + $signed({shr_s[PW-1], shr_s});
    assign clamp_s = clamp_pix(64'(filt_s), DW);
    assign out_s   = s3_byp ? s3_p4 : DW'(clamp_s);

    // S4: output register; data holds whenever the downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            frame_done <= 1'b0;
        end else if (!stall_s) begin
            m_valid    <= s3_valid;
            frame_done <= s3_valid && s3_last;
            if (s3_valid) begin
                m_data <= out_s;
            end
        end
    end

endmodule

// File: tb/tb_wiener_stream3x3.sv
// Randomised bench for wiener_stream3x3 on an 8x8 frame with an arithmetic reference model.
module tb_wiener_stream3x3;

    localparam int DW   = 8;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int FRAC = 16;
    localparam int NOUT = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic [17:0]   sigma_n2;
    logic          bypass;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;
    int img [H][W];
    int exp_data [$];
    bit exp_done [$];
    int obs [$];
    bit obs_done [$];
    bit rdy_mode = 1'b0;

    wiener_stream3x3 #(.DW(DW), .IMG_W(W), .IMG_H(H), .FRAC(FRAC)) dut (
        .clk        (clk),
        .rst        (rst),
        .sigma_n2   (sigma_n2),
        .bypass     (bypass),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference Wiener output for one 3x3 window given in raster order.
    function automatic int ref_pix(input int p [9], input longint sig, input bit byp,
                                   output longint var_o, output longint gain_o);
        longint sum, sq, mean, ex2, v, g, d, f;
        sum = 0;
        sq  = 0;
        for (int i = 0; i < 9; i++) begin
            sum += p[i];
            sq  += p[i] * p[i];
        end
        mean = sum / 9;
        ex2  = sq / 9;
        v    = (ex2 > mean * mean) ? ex2 - mean * mean : 0;
        g    = (v > sig && v != 0) ? ((v - sig) * (64'sd1 <<< FRAC)) / v : 0;
        d    = p[4] - mean;
        f    = mean + ((g * d) >>> FRAC);
        var_o  = v;
        gain_o = g;
        if (byp) return p[4];
        if (f < 0) return 0;
        if (f > 255) return 255;
        return int'(f);
    endfunction

    task automatic push_frame_expect(input longint sig, input bit byp);
        int p [9];
        longint v, g;
        for (int cy = 1; cy < H - 1; cy++) begin
            for (int cx = 1; cx < W - 1; cx++) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        p[r*3 + c] = img[cy - 1 + r][cx - 1 + c];
                exp_data.push_back(ref_pix(p, sig, byp, v, g));
                exp_done.push_back(cy == H - 2 && cx == W - 2);
            end
        end
    endtask

    task automatic send_pixel(input int d);
        bit ok;
        int n;
        s_valid = 1'b1;
        s_data  = DW'(d);
        n = 0;
        do begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 1000);
        chk(ok, "input_accept_timeout", n, 1000);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input longint sig, input bit byp, input int gap_pct,
                              input int chg_at, input longint sig2);
        push_frame_expect(sig, byp);
        sigma_n2 = 18'(sig);
        bypass   = byp;
        for (int i = 0; i < W * H; i++) begin
            if (i == chg_at) begin
                sigma_n2 = 18'(sig2);
                bypass   = ~byp;
            end
            if (int'($urandom_range(99)) < gap_pct) begin
                @(posedge clk);
                #1;
            end
            send_pixel(img[i / W][i % W]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_data.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk(exp_data.size() == 0, "drain_timeout", exp_data.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = int'($urandom_range(255));
    endtask

    task automatic fill_const(input int v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = v;
    endtask

    // Downstream ready: always high, or high about 30% of cycles.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rdy_mode ? (int'($urandom_range(99)) < 30) : 1'b1;
        end
    end

    // Output checker: every accepted beat against the model, stability during stalls.
    initial begin
        bit prev_stall;
        int prev_data;
        prev_stall = 1'b0;
        prev_data  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk(m_valid == 1'b1, "stall_valid_drop", m_valid, 1);
                    chk(int'(m_data) == prev_data, "stall_data_hold", m_data, prev_data);
                end
                if (!m_valid) begin
                    chk(frame_done == 1'b0, "done_without_valid", frame_done, 0);
                end
                if (m_valid && m_ready) begin
                    if (exp_data.size() == 0) begin
                        chk(1'b0, "unexpected_output", m_data, -1);
                    end else begin
                        chk(int'(m_data) == exp_data[0], "pixel", m_data, exp_data[0]);
                        chk(frame_done == exp_done[0], "frame_done", frame_done, exp_done[0]);
                        void'(exp_data.pop_front());
                        void'(exp_done.pop_front());
                    end
                    obs.push_back(int'(m_data));
                    obs_done.push_back(frame_done);
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = int'(m_data);
            end
        end
    end

    initial begin
        int p [9];
        longint v, g;
        int base, base2, n0, ndone;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        sigma_n2 = '0;
        bypass   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(s_ready == 1'b0, "reset_s_ready_low", s_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(s_ready == 1'b1, "post_reset_s_ready", s_ready, 1);
        chk(m_valid == 1'b0, "reset_m_valid", m_valid, 0);
        chk(m_data == '0, "reset_m_data", m_data, 0);
        chk(frame_done == 1'b0, "reset_frame_done", frame_done, 0);
        @(posedge clk);
        #1;

        // Hand-computed anchors for the model itself.
        for (int i = 0; i < 9; i++) p[i] = 100;
        p[4] = 190;
        chk(ref_pix(p, 500, 1'b0, v, g) == 140, "model_out_s500", ref_pix(p, 500, 1'b0, v, g), 140);
        chk(v == 800, "model_var", v, 800);
        chk(g == 24576, "model_gain", g, 24576);
        chk(ref_pix(p, 0, 1'b0, v, g) == 190, "model_out_s0", ref_pix(p, 0, 1'b0, v, g), 190);
        chk(ref_pix(p, 1000, 1'b0, v, g) == 110, "model_out_s1000", ref_pix(p, 1000, 1'b0, v, g), 110);

        // Constant frame.
        fill_const(100);
        base = obs.size();
        send_frame(500, 1'b0, 0, -1, 0);
        drain();
        chk(obs.size() - base == NOUT, "const_count", obs.size() - base, NOUT);
        ndone = 0;
        for (int i = base; i < obs.size(); i++) begin
            chk(obs[i] == 100, "const_value", obs[i], 100);
            ndone += int'(obs_done[i]);
        end
        chk(ndone == 1, "const_done_count", ndone, 1);
        chk(obs_done[base + NOUT - 1] == 1'b1, "const_done_last", obs_done[base + NOUT - 1], 1);

        // Single bright centre at (1,1) under three noise levels.
        fill_const(100);
        img[1][1] = 190;
        base = obs.size();
        send_frame(500, 1'b0, 0, -1, 0);
        drain();
        chk(obs[base] == 140, "window_s500", obs[base], 140);
        base = obs.size();
        send_frame(0, 1'b0, 0, -1, 0);
        drain();
        chk(obs[base] == 190, "window_s0", obs[base], 190);
        base = obs.size();
        send_frame(1000, 1'b0, 0, -1, 0);
        drain();
        chk(obs[base] == 110, "window_s1000", obs[base], 110);

        // Bypass on a ramp: outputs are the interior pixels in raster order.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = (x * 17 + y * 29) & 255;
        base = obs.size();
        send_frame(0, 1'b1, 0, -1, 0);
        drain();
        for (int i = 0; i < NOUT; i++)
            chk(obs[base + i] == img[1 + i / (W - 2)][1 + i % (W - 2)], "bypass_ramp",
                obs[base + i], img[1 + i / (W - 2)][1 + i % (W - 2)]);

        // Same random frame with and without downstream back-pressure.
        fill_random();
        base = obs.size();
        send_frame(300, 1'b0, 10, -1, 0);
        drain();
        rdy_mode = 1'b1;
        base2 = obs.size();
        send_frame(300, 1'b0, 10, -1, 0);
        drain();
        for (int i = 0; i < NOUT; i++)
            chk(obs[base2 + i] == obs[base + i], "stall_vs_nostall", obs[base2 + i], obs[base + i]);

        // Back-to-back random frames under back-pressure and input gaps.
        for (int f = 0; f < 3; f++) begin
            fill_random();
            send_frame(longint'($urandom_range(3000)), 1'b0, 15, -1, 0);
        end
        drain();
        rdy_mode = 1'b0;

        // Abort a frame right after two windows complete; nothing may emerge.
        fill_random();
        n0 = obs.size();
        sigma_n2 = 18'd200;
        bypass   = 1'b0;
        for (int i = 0; i < 2 * W + 4; i++)
            send_pixel(img[i / W][i % W]);
        rst = 1'b1;
        @(negedge clk);
        chk(s_ready == 1'b0, "midframe_reset_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk(obs.size() == n0, "aborted_frame_silent", obs.size(), n0);
        fill_random();
        base = obs.size();
        send_frame(200, 1'b0, 5, -1, 0);
        drain();
        chk(obs.size() - base == NOUT, "after_reset_count", obs.size() - base, NOUT);

        // Controls changed mid-frame apply only from the next frame.
        fill_random();
        send_frame(0, 1'b0, 0, 20, 1000);
        fill_random();
        send_frame(1000, 1'b1, 0, -1, 0);
        fill_random();
        send_frame(1000, 1'b1, 0, 30, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wiener_stream3x3.md
# wiener_stream3x3

Streaming, parametrised 3x3 spatial Wiener filter. It accepts a raster-scan pixel stream over a valid/ready handshake and buffers two image lines internally to form 3x3 windows. It emits the filtered interior pixels through a fixed-latency stalling pipeline. It supersedes the standalone combinational window filter with configurable pixel width, configurable frame size, a run-time noise variance, and a bypass mode.

## Interface
- DW, 8: pixel width in bits.
- IMG_W, 640: frame width in pixels (>=3).
- IMG_H, 480: frame height in pixels (>=3).
- FRAC, 16: fractional bits of the gain (Q.FRAC).
- clk  in  1  clock, rising edge; the only clock.
- rst  in  1  synchronous, active-high reset.
- sigma_n2  in  2*DW+2  noise variance; sampled at frame start.
- bypass  in  1  1 = output the window centre unfiltered; sampled at frame start.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  block can accept a pixel.
- s_data  in  DW  input pixel, raster order, first pixel = (0,0).
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DW  filtered pixel.
- frame_done  out  1  one-cycle pulse with the output beat of the last interior pixel.

## Operation
- Input transfer occurs when s_valid && s_ready. Column counter x runs 0..IMG_W-1 and row counter y runs 0..IMG_H-1. Both wrap to 0 after (IMG_W-1, IMG_H-1), and the next frame follows with no gap.
- sigma_n2 and bypass are latched into shadow registers on the transfer of pixel (0,0). They hold for the whole frame.
- Two DW x IMG_W line buffers plus a 3x3 register window. Accepting pixel (x,y) with x>=2 and y>=2 completes the window centred at (x-1,y-1). p0..p8 are in raster order, rows y-2..y, and p4 is the centre.
- Only interior pixels are output, (IMG_W-2)*(IMG_H-2) per frame, in raster order. Border pixels produce no output.
- Arithmetic (all unsigned unless noted, floor division):
  - sum = Σp (DW+4 bits); sumsq = Σp² (2DW+4 bits).
  - mean = sum/9; Ex2 = sumsq/9.
  - var = Ex2 > mean² ? Ex2 − mean² : 0.
  - gain = (var > sigma && var != 0) ? ((var − sigma) << FRAC)/var : 0.
  - delta = p4 − mean (signed DW+2 bits); filt = mean + ((gain·delta) >>> FRAC), with an arithmetic (floor) shift.
  - m_data = clamp(filt, 0, 2^DW − 1).
  - bypass = 1: m_data = p4.
- Pipeline stages:
  - S1 window sums.
  - S2 mean/Ex2/var.
  - S3 gain.
  - S4 filter and clamp into the output register.

## Timing
- Latency: the window-completing input transfer at cycle t gives m_valid at cycle t+4 when there is no stall.
- Stall: stall = m_valid && !m_ready. While stall is high, the whole pipeline, window, line buffers and counters freeze, and s_ready = !stall. m_data is held stable while m_valid && !m_ready.
- Throughput is 1 pixel/cycle with m_ready held high.
- frame_done asserts on the cycle the last interior pixel, (IMG_W-2, IMG_H-2), is presented. It is held with m_valid until that beat transfers.
- Reset values: s_ready=0 during rst and 1 on the first cycle after; m_valid=0, m_data=0, frame_done=0, x=y=0, all stage valids 0, shadow sigma=0, shadow bypass=0. Line-buffer contents are don't-care.
- Reset mid-frame: in-flight results are discarded with no output. The next accepted pixel is (0,0).
- An input gap (s_valid=0) inserts bubbles and does not corrupt the windows. Row wrap must not mix pixels from adjacent rows into a window.
- Changing sigma_n2 or bypass mid-frame has no effect until the next (0,0).

## Structure
- Package wiener_pkg holds:
  - width helper functions: sum width, sumsq width, var width;
  - the FRAC default;
  - the clamp function;
  - the window struct/array typedef, 9 x DW.
- Sub-module wiener_linebuf holds the two-line buffer, the 3x3 window shift, the x/y counters and the window-valid generation. The top module holds the S1–S4 arithmetic and the handshake.

## Test plan
- Constant frame, all pixels 100, sigma=500, IMG_W=IMG_H=8. Required: 36 outputs, all equal to 100; frame_done fires once, on the 36th beat.
- Single window all 100 with centre 190, sigma=500. Required: var=800, gain=24576, output 140. With sigma=0 the output is 190; with sigma=1000 the output is 110 (the mean).
- bypass=1 on a ramp frame. Required: each output equals the input centre pixel at (x,y), in raster order.
- m_ready toggled randomly, at a 30% duty cycle. Required: the output sequence is identical to the m_ready=1 run, and m_data is stable during every stall.
- rst asserted for 1 cycle mid-frame, then a full frame is sent. Required: no output from the aborted frame, and the new frame is bit-exact against the model.
- sigma_n2 changed mid-frame from 0 to 1000. Required: the current frame uses 0 throughout, and the next frame uses 1000.
